// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_pkg
// Purpose  : Shared types and constants for the FIFO stream reader.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int DEFAULT_DATA_W = 32;

endpackage : fifo_rd_pkg
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_skid
// Purpose  : Two-entry registered output buffer with simultaneous write/pop.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        occ_q, occ_d;
    logic              valid_q, valid_d;
    logic              do_pop;

    assign do_pop = pop && (occ_q != 2'd0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        if (do_pop && wr) begin
            // Pop and write together: occupancy unchanged, data shifts forward.
            if (occ_q == 2'd1) begin
                head_d = wdata;
            end else begin
                head_d = tail_q;
                tail_d = wdata;
            end
        end else if (do_pop) begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
        end else if (wr && (occ_q != 2'd2)) begin
            if (occ_q == 2'd0) begin
                head_d = wdata;
            end else begin
                tail_d = wdata;
            end
            occ_d = occ_q + 2'd1;
        end
        valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
        end
    end

    assign head_data  = head_q;
    assign head_valid = valid_q;
    assign occ        = occ_q;

endmodule : fifo_rd_skid
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : FIFO read engine: pop control, latency absorption, burst stream.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              valid,
    input  logic              empty,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              err
);

    localparam int              CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    rd_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inflight_q;
    logic             err_q, err_d;
    logic             post_rst_q;
    logic [1:0]       occ;
    logic             beat;
    logic             wr;
    logic [2:0]       held;
    logic [2:0]       limit;

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr),
        .wdata      (rd_data),
        .pop        (m_ready),
        .head_data  (m_data),
        .head_valid (m_valid),
        .occ        (occ)
    );

    assign beat  = m_valid && m_ready;
    assign wr    = valid && inflight_q;
    assign held  = {1'b0, occ} + {2'b00, inflight_q};
    // held - beat < 2, rearranged to stay unsigned
    assign limit = 3'd2 + {2'b00, beat};
    assign rd_en = rst && en && !empty && (held < limit);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = ((occ != 2'd0) || inflight_q) ? DRAIN : IDLE;
            DRAIN: begin
                if (en)                                   state_d = RUN;
                else if ((occ == 2'd0) && !inflight_q)    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (beat) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end
    end

    // The first cycle after reset release ignores stray read data.
    always_comb begin
        err_d = err_q;
        if (!post_rst_q && (valid != inflight_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            post_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= rd_en;
            err_q      <= err_d;
            post_rst_q <= 1'b0;
        end
    end

    assign m_last = m_valid && (cnt_q == LAST_CNT);
    assign busy   = (state_q != IDLE);
    assign err    = err_q;

endmodule : fifo_stream_reader
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Directed self-checking bench with a queue-based stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          valid = 1'b0;
    logic          empty = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          busy;
    logic          err;

    fifo_stream_reader #(.DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .valid   (valid),
        .empty   (empty),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            last_idx_q[$];
    logic          inj_valid = 1'b1;
    logic [DW-1:0] inj_data = 32'h0000_BAD0;
    logic          pop_now;
    logic          run_chk = 1'b0;
    int            cyc = 0;
    int            beat_idx = 0;
    int            held = 0;
    int            ph_pops = 0, ph_beats = 0, ph_lasts = 0;
    int            first_pop = -1, first_beat = -1, last_beat = -1;
    logic [DW-1:0] first_data = '1;
    bit            b;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(DW'(base + i));
            exp_q.push_back(DW'(base + i));
        end
        empty = 1'b0;
    endtask

    task automatic clr_phase();
        ph_pops = 0; ph_beats = 0; ph_lasts = 0;
        first_pop = -1; first_beat = -1; last_beat = -1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO with one-cycle read latency; also injects unsolicited data on request.
    initial begin
        forever begin
            @(negedge clk);
            pop_now = rd_en;
            @(posedge clk);
            #1;
            if (pop_now && fifo_q.size() != 0) begin
                valid   = 1'b1;
                rd_data = fifo_q.pop_front();
            end else begin
                valid   = inj_valid;
                rd_data = inj_data;
            end
            empty = (fifo_q.size() == 0);
        end
    end

    // Stream model: in-order words, m_last every BL-th beat since reset.
    initial begin
        forever begin
            @(negedge clk);
            if (run_chk) begin
                b = m_valid && m_ready;
                check("pop_while_empty", {63'd0, rd_en && empty}, 64'd0);
                if (prev_stall) begin
                    check("stall_valid", {63'd0, m_valid}, 64'd1);
                    check("stall_data", {32'd0, m_data}, {32'd0, prev_data});
                end
                check("m_last", {63'd0, m_last},
                      {63'd0, m_valid && ((beat_idx % BL) == BL - 1)});
                if (b) begin
                    check("beat_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                    if (exp_q.size() != 0)
                        check("m_data", {32'd0, m_data}, {32'd0, exp_q.pop_front()});
                    if (m_last) begin
                        last_idx_q.push_back(beat_idx);
                        ph_lasts++;
                    end
                    if (first_beat < 0) begin
                        first_beat = cyc;
                        first_data = m_data;
                    end
                    last_beat = cyc;
                    beat_idx++;
                    ph_beats++;
                end
                if (rd_en) begin
                    ph_pops++;
                    if (first_pop < 0) first_pop = cyc;
                end
                held = held + (rd_en ? 1 : 0) - (b ? 1 : 0);
                check("held_le_2", {63'd0, held <= 2}, 64'd1);
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with stray valid asserted throughout.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", {63'd0, rd_en}, 64'd0);
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_data", {32'd0, m_data}, 64'd0);
        check("rst_m_last", {63'd0, m_last}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        inj_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rel_err_1", {63'd0, err}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("rel_err_2", {63'd0, err}, 64'd0);
        check("rel_m_valid", {63'd0, m_valid}, 64'd0);
        run_chk = 1'b1;

        // Streaming 0x00..0x1F at full rate.
        @(posedge clk); #2;
        clr_phase();
        load(0, 32);
        m_ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 200 && ph_beats < 32; i++) @(posedge clk);
        #2;
        check("stream_beats", 64'(ph_beats), 64'd32);
        check("stream_latency", 64'(first_beat - first_pop), 64'd2);
        check("stream_back2back", 64'(last_beat - first_beat), 64'd31);
        check("stream_first_word", {32'd0, first_data}, 64'd0);
        check("stream_lasts", 64'(ph_lasts), 64'd2);
        if (last_idx_q.size() >= 2) begin
            check("stream_last0", 64'(last_idx_q[0]), 64'd15);
            check("stream_last1", 64'(last_idx_q[1]), 64'd31);
        end
        en = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(posedge clk);
        #2;
        check("stream_idle", {63'd0, busy}, 64'd0);

        // Backpressure: ready low 5 cycles, high 3, repeated.
        clr_phase();
        load(32'h100, 8);
        en = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            m_ready = 1'b0;
            repeat (5) @(posedge clk);
            #2;
            m_ready = 1'b1;
            repeat (3) @(posedge clk);
            #2;
        end
        check("bp_beats", 64'(ph_beats), 64'd8);
        en = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(posedge clk);
        #2;

        // Empty boundary: exactly three words available.
        clr_phase();
        load(32'h200, 3);
        en = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("empty_pops", 64'(ph_pops), 64'd3);
        check("empty_beats", 64'(ph_beats), 64'd3);
        en = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(posedge clk);
        #2;

        // Drain: stall, drop en with one buffered and one in flight.
        m_ready = 1'b0;
        load(32'h300, 6);
        clr_phase();
        en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        en = 1'b0;
        @(negedge clk);
        check("drain_no_pop", {63'd0, rd_en}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("drain_busy", {63'd0, busy}, 64'd1);
        check("drain_valid", {63'd0, m_valid}, 64'd1);
        check("drain_pops", 64'(ph_pops), 64'd2);
        @(posedge clk); #2;
        m_ready = 1'b1;
        for (int i = 0; i < 20 && busy; i++) @(posedge clk);
        #2;
        check("drain_idle", {63'd0, busy}, 64'd0);
        check("drain_beats", 64'(ph_beats), 64'd2);
        clr_phase();
        en = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        check("resume_beats", 64'(ph_beats), 64'd4);
        check("resume_lasts", 64'(ph_lasts), 64'd1);
        en = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(posedge clk);
        #2;

        // Unsolicited read data.
        check("pre_err", {63'd0, err}, 64'd0);
        inj_data  = 32'h0000_DEAD;
        inj_valid = 1'b1;
        @(posedge clk); #2;
        inj_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("err_set", {63'd0, err}, 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("err_held", {63'd0, err}, 64'd1);
        check("err_no_beat", {63'd0, m_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fifo_stream_reader
`default_nettype wire
